// File: rtl/ddr_package.sv
// Shared types for the DDR4 memory-model burst responder.
// CAS queue entry layout, responder FSM states and command codes.
package ddr_package;

    localparam int DDR_COL_W = 10;
    localparam int DDR_LAT_W = 5;

    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_RD,
        RESP_WR
    } resp_fsm_type;

    typedef struct packed {
        logic [1:0]           rw;
        logic [DDR_COL_W-1:0] col;
        logic [DDR_LAT_W-1:0] cnt;
    } cas_entry_t;

    // A latency of 0 behaves like 1; the stored count is already
    // one step down because the enqueue cycle counts.
    function automatic logic [DDR_LAT_W-1:0] lat_to_cnt(
        input logic [DDR_LAT_W-1:0] lat
    );
        return (lat == '0) ? '0 : lat - DDR_LAT_W'(1);
    endfunction

endpackage

// File: rtl/cas_lat_queue.sv
// In-order CAS queue with a saturating latency countdown per entry.
// Flags entries whose count has just reached zero.
module cas_lat_queue
    import ddr_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock_t,
    input  logic       reset,
    input  logic       push,
    input  cas_entry_t push_entry,
    input  logic       pop,
    output cas_entry_t head,
    output logic       head_due,
    output logic       head_new_due,
    output logic       other_new_due,
    output logic       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    cas_entry_t       slot [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] new_zero;
    logic [DEPTH-1:0] head_mask;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok  = pop && vld[rd_ptr];
    assign push_ok = push && (count != CW'(DEPTH) || pop_ok);

    // Ring pointers and occupancy.
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Slot contents: load on push, otherwise count down to zero.
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            vld      <= '0;
            new_zero <= '0;
            for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok && wr_ptr == PW'(i)) begin
                    slot[i]     <= push_entry;
                    vld[i]      <= 1'b1;
                    new_zero[i] <= (push_entry.cnt == '0);
                end else begin
                    if (pop_ok && rd_ptr == PW'(i)) vld[i] <= 1'b0;
                    if (slot[i].cnt != '0)
                        slot[i].cnt <= slot[i].cnt - DDR_LAT_W'(1);
                    new_zero[i] <= vld[i] &&
                                   (slot[i].cnt == DDR_LAT_W'(1));
                end
            end
        end
    end

    assign head_mask     = DEPTH'(1) << rd_ptr;
    assign head          = slot[rd_ptr];
    assign head_due      = vld[rd_ptr] && (head.cnt == '0);
    assign head_new_due  = vld[rd_ptr] && new_zero[rd_ptr];
    assign other_new_due = |(vld & new_zero & ~head_mask);
    assign full          = (count == CW'(DEPTH));

endmodule

// File: rtl/ddr_burst_responder.sv
// DRAM-side CAS burst responder: queues RD/WR commands, then plays
// read bursts onto DQ or captures write bursts after CL/CWL.
module ddr_burst_responder
    import ddr_package::*;
#(
    parameter int DATA_W  = 8,
    parameter int BL      = 8,
    parameter int COL_W   = DDR_COL_W,
    parameter int MAX_OUT = 4,
    parameter int LAT_W   = DDR_LAT_W
) (
    input  logic              clock_t,
    input  logic              reset,
    input  logic              cas_valid,
    input  logic [1:0]        cas_rw,
    input  logic [COL_W-1:0]  cas_col,
    input  logic [LAT_W-1:0]  rd_lat,
    input  logic [LAT_W-1:0]  wr_lat,
    output logic              cas_ready,
    output logic [COL_W-1:0]  mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] dq_in,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    output logic              burst_busy,
    output logic              err_collision,
    output logic              err_overflow
);

    localparam int BW = $clog2(BL);

    resp_fsm_type     state;
    resp_fsm_type     state_nx;
    logic [BW-1:0]    beat;
    logic [COL_W-1:0] cur_col;
    cas_entry_t       head;
    cas_entry_t       push_entry;
    logic             head_due;
    logic             head_new_due;
    logic             other_new_due;
    logic             q_full;
    logic             cmd_ok;
    logic             last_beat;
    logic             start;
    logic             push;
    logic             drop;
    logic             collide;
    logic             unused_bits;

    assign cmd_ok    = cas_valid &&
                       (cas_rw == RW_READ || cas_rw == RW_WRITE);
    assign last_beat = (beat == BW'(BL - 1));
    assign start     = head_due && (state == RESP_IDLE || last_beat);

    // A pop on the same edge frees a slot, so a full queue still accepts.
    assign push = cmd_ok && (!q_full || start);
    assign drop = cmd_ok && q_full && !start;

    assign push_entry.rw  = cas_rw;
    assign push_entry.col = cas_col;
    assign push_entry.cnt = lat_to_cnt(
        (cas_rw == RW_READ) ? rd_lat : wr_lat);

    // Either a later entry is stuck behind the head, or the head came
    // due while the current burst still has beats to go.
    assign collide = other_new_due || (head_new_due && !start);

    cas_lat_queue #(
        .DEPTH(MAX_OUT)
    ) u_queue (
        .clock_t      (clock_t),
        .reset        (reset),
        .push         (push),
        .push_entry   (push_entry),
        .pop          (start),
        .head         (head),
        .head_due     (head_due),
        .head_new_due (head_new_due),
        .other_new_due(other_new_due),
        .full         (q_full)
    );

    // Responder state register.
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) state <= RESP_IDLE;
        else       state <= state_nx;
    end

    // Next state and burst strobes.
    always_comb begin
        state_nx   = state;
        dq_oe      = 1'b0;
        mem_we     = 1'b0;
        burst_busy = 1'b0;
        unique case (state)
            RESP_RD: begin
                dq_oe      = 1'b1;
                burst_busy = 1'b1;
            end
            RESP_WR: begin
                mem_we     = 1'b1;
                burst_busy = 1'b1;
            end
            default: ;
        endcase
        if (start)
            state_nx = (head.rw == RW_WRITE) ? RESP_WR : RESP_RD;
        else if (state != RESP_IDLE && last_beat)
            state_nx = RESP_IDLE;
    end

    // Beat counter and latched column of the running burst.
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            beat    <= '0;
            cur_col <= '0;
        end else if (start) begin
            beat    <= '0;
            cur_col <= head.col;
        end else if (state != RESP_IDLE) begin
            beat <= last_beat ? '0 : beat + BW'(1);
        end
    end

    // One-cycle error pulses.
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            err_collision <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            err_collision <= collide;
            err_overflow  <= drop;
        end
    end

    assign cas_ready = !q_full;
    assign mem_addr  = burst_busy ? {cur_col[COL_W-1:BW], beat} : '0;
    assign mem_wdata = dq_in;
    assign dq_out    = dq_oe ? mem_rdata : '0;

    // Count and low column bits are deliberately not consumed here.
    assign unused_bits = ^{head.cnt, cur_col[BW-1:0]};

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Scoreboard bench for ddr_burst_responder: directed CAS scenarios,
// expected beats queued at issue, checked by a negedge monitor.
module tb_ddr_burst_responder;
    import ddr_package::*;

    logic       clock_t = 1'b0;
    logic       reset   = 1'b0;
    logic       cas_valid;
    logic [1:0] cas_rw;
    logic [9:0] cas_col;
    logic [4:0] rd_lat;
    logic [4:0] wr_lat;
    logic       cas_ready;
    logic [9:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] dq_in;
    logic [7:0] dq_out;
    logic       dq_oe;
    logic       burst_busy;
    logic       err_collision;
    logic       err_overflow;

    typedef struct {
        int         edge_no;
        bit         wr;
        logic [9:0] addr;
        logic [7:0] data;
    } beat_t;

    beat_t      sb[$];
    logic [7:0] mem [1024];
    bit         mem_init = 1'b1;
    int         cyc = 0;
    int         wr_first = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    int         n_col = 0;
    int         n_ovf = 0;

    always #5 clock_t = ~clock_t;

    ddr_burst_responder dut (
        .clock_t      (clock_t),
        .reset        (reset),
        .cas_valid    (cas_valid),
        .cas_rw       (cas_rw),
        .cas_col      (cas_col),
        .rd_lat       (rd_lat),
        .wr_lat       (wr_lat),
        .cas_ready    (cas_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .dq_in        (dq_in),
        .dq_out       (dq_out),
        .dq_oe        (dq_oe),
        .burst_busy   (burst_busy),
        .err_collision(err_collision),
        .err_overflow (err_overflow)
    );

    function automatic logic [7:0] pat(input logic [9:0] a);
        return a[7:0] ^ {a[9:8], 6'h1A};
    endfunction

    assign mem_rdata = mem[mem_addr];
    assign dq_in     = 8'hA0 + 8'(cyc - wr_first);

    // Edge counter: cyc equals the number of the last rising edge.
    always @(posedge clock_t) cyc <= cyc + 1;

    // Array model: preload a pattern, then absorb DUT writes.
    always @(posedge clock_t) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(10'(i));
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)",
                     nm, act, exp_v, cyc);
        end
    endtask

    // Error pulse counters, sampled mid-cycle.
    always @(negedge clock_t) begin
        if (err_collision) n_col++;
        if (err_overflow)  n_ovf++;
    end

    // Monitor: pop the expected beat for this edge, else demand idle.
    always @(negedge clock_t) begin : monitor
        beat_t       b;
        logic [20:0] act;
        logic [20:0] exp_v;
        if (sb.size() != 0 && sb[0].edge_no == cyc) begin
            b     = sb.pop_front();
            exp_v = {~b.wr, b.wr, 1'b1, b.addr, b.data};
            act   = {dq_oe, mem_we, burst_busy, mem_addr,
                     b.wr ? mem_wdata : dq_out};
            chk($sformatf("beat@%0d", b.edge_no), 32'(act),
                32'(exp_v));
        end else begin
            chk("idle", 32'({dq_oe, mem_we, burst_busy}), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clock_t);
        #1;
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e) tick();
    endtask

    task automatic issue(input int e, input logic [1:0] rw,
                         input logic [9:0] col, input logic [4:0] lat);
        goto_edge(e - 1);
        cas_valid = 1'b1;
        cas_rw    = rw;
        cas_col   = col;
        if (rw == RW_WRITE) wr_lat = lat;
        else                rd_lat = lat;
        goto_edge(e);
        cas_valid = 1'b0;
    endtask

    task automatic expect_burst(input int first, input bit wr,
                                input logic [9:0] col, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.edge_no = first + k;
            b.wr      = wr;
            b.addr    = {col[9:3], 3'(k)};
            b.data    = wr ? 8'hA0 + 8'(k) : pat(b.addr);
            sb.push_back(b);
        end
    endtask

    task automatic finish_case(input string nm, input int e_col,
                               input int e_ovf);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "/drained"}, 32'(sb.size()), 32'd0);
        repeat (4) tick();
        chk({nm, "/collision"}, 32'(n_col), 32'(e_col));
        chk({nm, "/overflow"}, 32'(n_ovf), 32'(e_ovf));
        chk({nm, "/ready"}, 32'(cas_ready), 32'd1);
        n_col = 0;
        n_ovf = 0;
    endtask

    task automatic read_basic(input string nm);
        int base;
        base = cyc;
        issue(base + 3, 2'b11, 10'h300, 5'd1);
        expect_burst(base + 21, 1'b0, 10'h040, 8);
        issue(base + 10, RW_READ, 10'h040, 5'd11);
        finish_case(nm, 0, 0);
    endtask

    initial begin
        int base;
        cas_valid = 1'b0;
        cas_rw    = 2'b00;
        cas_col   = '0;
        rd_lat    = '0;
        wr_lat    = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst/strobes", 32'({dq_oe, mem_we, burst_busy}), 32'd0);
        chk("rst/addr", 32'(mem_addr), 32'd0);
        chk("rst/ready", 32'(cas_ready), 32'd1);
        chk("rst/errs", 32'({err_collision, err_overflow}), 32'd0);
        tick();
        mem_init = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (2) tick();

        read_basic("read");

        base = cyc;
        wr_first = base + 14;
        expect_burst(base + 14, 1'b1, 10'h108, 8);
        issue(base + 5, RW_WRITE, 10'h108, 5'd9);
        finish_case("write", 0, 0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("write/mem%0d", k),
                32'(mem[10'h108 + 10'(k)]), 32'(8'hA0 + 8'(k)));

        base = cyc;
        expect_burst(base + 21, 1'b0, 10'h040, 8);
        expect_burst(base + 29, 1'b0, 10'h080, 8);
        issue(base + 10, RW_READ, 10'h040, 5'd11);
        issue(base + 18, RW_READ, 10'h080, 5'd11);
        finish_case("seamless", 0, 0);

        base = cyc;
        expect_burst(base + 21, 1'b0, 10'h040, 8);
        expect_burst(base + 29, 1'b0, 10'h0C0, 8);
        issue(base + 10, RW_READ, 10'h040, 5'd11);
        issue(base + 14, RW_READ, 10'h0C0, 5'd11);
        finish_case("overlap", 1, 0);

        base = cyc;
        expect_burst(base + 25, 1'b0, 10'h000, 8);
        expect_burst(base + 33, 1'b0, 10'h010, 8);
        expect_burst(base + 41, 1'b0, 10'h020, 8);
        expect_burst(base + 49, 1'b0, 10'h030, 8);
        issue(base + 5, RW_READ, 10'h000, 5'd20);
        issue(base + 6, RW_READ, 10'h010, 5'd20);
        issue(base + 7, RW_READ, 10'h020, 5'd20);
        issue(base + 8, RW_READ, 10'h030, 5'd20);
        chk("full/ready_low", 32'(cas_ready), 32'd0);
        issue(base + 9, RW_READ, 10'h050, 5'd20);
        chk("full/still_low", 32'(cas_ready), 32'd0);
        finish_case("full", 3, 1);

        base = cyc;
        expect_burst(base + 6, 1'b0, 10'h010, 8);
        issue(base + 5, RW_READ, 10'h010, 5'd0);
        finish_case("lat0", 0, 0);

        base = cyc;
        wr_first = base + 14;
        expect_burst(base + 14, 1'b1, 10'h200, 3);
        issue(base + 5, RW_WRITE, 10'h200, 5'd9);
        goto_edge(base + 17);
        #1 reset = 1'b1;
        #1;
        chk("rstmid/strobes", 32'({dq_oe, mem_we, burst_busy}), 32'd0);
        chk("rstmid/addr", 32'(mem_addr), 32'd0);
        chk("rstmid/ready", 32'(cas_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        repeat (30) tick();
        finish_case("rstmid", 0, 0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("rstmid/mem%0d", k),
                32'(mem[10'h200 + 10'(k)]), 32'(8'hA0 + 8'(k)));
        chk("rstmid/mem3", 32'(mem[10'h203]), 32'(pat(10'h203)));

        read_basic("read_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
